// File: rtl/ifm_row_buffer.sv
// Three-row IFM line buffer: each row is an independent register-file buffer with
// its own write/read pointers and fill level; overflow/underflow flags are sticky.
module ifm_row_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int IFM_WIDTH  = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  wr_clr,
  input  logic                  rd_en,
  input  logic                  rd_clr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_drop,
  output logic                  rd_refuse
);
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(IFM_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [IFM_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, fill;
  logic [ADDR_WIDTH-1:0] eff_wp, eff_rp, wp_nxt;
  logic                  wr_ok, rd_ok;

  // Clears act in the same cycle as a strobe, so the strobe targets address 0.
  assign eff_wp    = wr_clr ? '0 : wr_ptr;
  assign eff_rp    = rd_clr ? '0 : rd_ptr;
  assign wp_nxt    = eff_wp + ONE;
  assign wr_ok     = wr_en && (eff_wp < DEPTH);
  assign rd_ok     = rd_en && (eff_rp < fill);
  assign wr_drop   = wr_en && !wr_ok;
  assign rd_refuse = rd_en && !rd_ok;
  assign full      = (wr_ptr == DEPTH);
  assign empty     = (fill == '0);

  always_ff @(posedge clk1) begin
    if (wr_ok) mem[eff_wp] <= din;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wp_nxt;
        if (wp_nxt > fill) fill <= wp_nxt;
      end else if (wr_clr && !wr_en) begin
        wr_ptr <= '0;
      end
      // Read sees pre-edge fill and memory: no write-to-read bypass.
      dout_vld <= rd_ok;
      if (rd_ok) begin
        dout   <= mem[eff_rp];
        rd_ptr <= eff_rp + ONE;
      end else if (rd_clr && !rd_en) begin
        rd_ptr <= '0;
      end
    end
  end
endmodule

module ifm_row_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int IFM_WIDTH  = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  wr_en_1,
  input  logic                  wr_en_2,
  input  logic                  wr_en_3,
  input  logic                  wr_clr,
  input  logic                  rd_en_1,
  input  logic                  rd_en_2,
  input  logic                  rd_en_3,
  input  logic                  rd_clr,
  input  logic [DATA_WIDTH-1:0] din_1,
  input  logic [DATA_WIDTH-1:0] din_2,
  input  logic [DATA_WIDTH-1:0] din_3,
  output logic [DATA_WIDTH-1:0] dout_1,
  output logic [DATA_WIDTH-1:0] dout_2,
  output logic [DATA_WIDTH-1:0] dout_3,
  output logic [2:0]            dout_valid,
  output logic [2:0]            row_full,
  output logic [2:0]            row_empty,
  output logic                  err_ovf,
  output logic                  err_udf
);
  localparam int NUM_ROWS = 3;

  logic [NUM_ROWS-1:0]                 wr_en_v, rd_en_v, wr_drop, rd_refuse;
  logic [NUM_ROWS-1:0][DATA_WIDTH-1:0] din_v, dout_v;

  assign wr_en_v = {wr_en_3, wr_en_2, wr_en_1};
  assign rd_en_v = {rd_en_3, rd_en_2, rd_en_1};
  assign din_v   = {din_3, din_2, din_1};
  assign dout_1  = dout_v[0];
  assign dout_2  = dout_v[1];
  assign dout_3  = dout_v[2];

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    ifm_row_lane #(
      .DATA_WIDTH(DATA_WIDTH), .IFM_WIDTH(IFM_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .clk1      (clk1),
      .rst_n     (rst_n),
      .wr_en     (wr_en_v[r]),
      .wr_clr    (wr_clr),
      .rd_en     (rd_en_v[r]),
      .rd_clr    (rd_clr),
      .din       (din_v[r]),
      .dout      (dout_v[r]),
      .dout_vld  (dout_valid[r]),
      .full      (row_full[r]),
      .empty     (row_empty[r]),
      .wr_drop   (wr_drop[r]),
      .rd_refuse (rd_refuse[r])
    );
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (|wr_drop)   err_ovf <= 1'b1;
      if (|rd_refuse) err_udf <= 1'b1;
    end
  end
endmodule
